alu_muldiv: RTL and testbench

Parametrised successor to the 32-bit MIPS ALU. It keeps every single-cycle logic, arithmetic and shift operation, generalises the datapath width, and adds SRA and SLT. It also adds an iterative multiply/divide unit with HI/LO registers and a Start/Busy/Done handshake that the control unit uses to stall the pipeline. It sits in the EX stage, where the plain ALU sits today.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 rtl/alu_muldiv.sv | 83 ++++++++
 tb/tb_alu_muldiv.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the EX-stage ALU with iterative multiply/divide.
//   - 4-bit ALUOperation codes (combinational, read and sequential groups)
//   - muldiv_unit state encoding (IDLE / RUN / FINISH)
//   - is_seq_op(): which opcodes launch the multiply/divide unit on Start
//
//   Optional feature macro: ALU_SIGNED_MULDIV_EN
//     defined   -> MULT (1100) and DIV (1101) are sequential opcodes
//     undefined -> 1100 and 1101 are undefined opcodes
// -----------------------------------------------------------------------------
package alu_pkg;

    // Combinational opcodes
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRA   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1110;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // HI/LO reads
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;

    // Sequential (multi-cycle) opcodes
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;

    // muldiv_unit state encoding
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] FINISH   = 2'd2;

    // True for opcodes that start the multiply/divide unit.
    function automatic logic is_seq_op(input logic [3:0] op);
`ifdef ALU_SIGNED_MULDIV_EN
        return (op == OP_MULTU) || (op == OP_DIVU) ||
               (op == OP_MULT)  || (op == OP_DIV);
`else
        return (op == OP_MULTU) || (op == OP_DIVU);
`endif
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide with HI/LO registers. One shift-add (multiply)
//   or restoring-division step per cycle for WIDTH cycles, then a FINISH
//   cycle that writes {hi,lo}. Latency from accepted start to done is
//   WIDTH+1 cycles; busy covers every cycle in between.
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous active-low reset (aborts any operation, clears HI/LO)
//     op     ALU opcode; only sequential opcodes launch an operation
//     a, b   operands, latched on the accepting edge
//     start  launch request, ignored while busy or for non-sequential ops
//     busy   operation in progress (RUN or FINISH)
//     done   one-cycle pulse, new hi/lo visible in the same cycle
//     hi, lo HI and LO registers
//
//   Optional feature macro: ALU_SIGNED_MULDIV_EN
//     defined -> MULT/DIV run on magnitudes and are sign-corrected in FINISH.
// -----------------------------------------------------------------------------
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]         state, state_nxt;
    logic [CNT_W-1:0]   cnt;

    // acc_hi/acc_lo double as partial product (multiply) or
    // remainder/quotient (divide); opnd is multiplicand or divisor.
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
    logic               is_div, neg_res, neg_rem, b_zero;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               accept, sgn_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef ALU_SIGNED_MULDIV_EN
    assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
`else
    assign sgn_op = 1'b0;
`endif

    assign accept = (state == IDLE) && start && is_seq_op(op);

    // Signed ops iterate on magnitudes. The most negative value maps onto
    // itself, which is the correct magnitude when read as unsigned.
    assign a_mag = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn_op && b[WIDTH-1]) ? -b : b;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift the whole {acc_hi,acc_lo} right by one.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

    // Restoring step: bring in the next dividend bit and trial-subtract.
    // The remainder is always below the divisor, so bit WIDTH of the
    // difference is a clean borrow flag.
    assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd};

    // Sign correction. Divide-by-zero keeps the all-ones quotient; the
    // remainder (|A| for a zero divisor) takes A's sign and so equals A.
    assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_fix  = (neg_res && !b_zero) ? -acc_lo : acc_lo;
    assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state == RUN) || (state == FINISH);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // Datapath, counter, HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= CNT_W'(WIDTH);
                        is_div  <= (op == OP_DIVU) || (op == OP_DIV);
                        neg_res <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem <= sgn_op && a[WIDTH-1];
                        b_zero  <= (b == '0);
                        acc_hi  <= '0;
                        if ((op == OP_DIVU) || (op == OP_DIV)) begin
                            acc_lo <= a_mag;
                            opnd   <= b_mag;
                        end else begin
                            acc_lo <= b_mag;
                            opnd   <= a_mag;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_sh[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    done_q <= 1'b1;
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
//   EX-stage ALU: single-cycle logic/arithmetic/shift/compare/LUI, HI/LO
//   reads, and an iterative multiply/divide unit (muldiv_unit) the control
//   unit stalls on via Busy/Done.
//
//   Ports
//     clk           rising-edge clock
//     reset         asynchronous active-low reset
//     ALUOperation  4-bit opcode (see alu_pkg)
//     A, B          operands (rs, rt/immediate)
//     Shamt         shift amount for SLL/SRA/SRL
//     Start         launch multiply/divide
//     Busy, Done    multiply/divide handshake
//     Zero          ALUResult == 0
//     ALUResult     combinational result (0 for sequential/undefined ops)
//     Hi, Lo        HI/LO registers
//
//   Optional feature macro: ALU_SIGNED_MULDIV_EN (signed MULT/DIV).
// -----------------------------------------------------------------------------
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic               Start,
    output logic               Busy,
    output logic               Done,
    output logic               Zero,
    output logic [WIDTH-1:0]   ALUResult,
    output logic [WIDTH-1:0]   Hi,
    output logic [WIDTH-1:0]   Lo
);

    // LUI splits the word in half, and the divider needs at least two bits.
    if ((WIDTH % 2) != 0 || WIDTH < 8) begin : g_bad_width
        $error("alu_muldiv: WIDTH must be even and >= 8");
    end

    muldiv_unit #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .op    (ALUOperation),
        .a     (A),
        .b     (B),
        .start (Start),
        .busy  (Busy),
        .done  (Done),
        .hi    (Hi),
        .lo    (Lo)
    );

    always_comb begin
        ALUResult = '0;
        case (ALUOperation)
            OP_AND:  ALUResult = A & B;
            OP_OR:   ALUResult = A | B;
            OP_NOR:  ALUResult = ~(A | B);
            OP_ADD:  ALUResult = A + B;
            OP_SUB:  ALUResult = A - B;
            OP_SLL:  ALUResult = A << Shamt;
            OP_SRA:  ALUResult = $signed(A) >>> Shamt;
            OP_SRL:  ALUResult = A >> Shamt;
            OP_SLT:  ALUResult = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_LUI:  ALUResult = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_MFHI: ALUResult = Hi;
            OP_MFLO: ALUResult = Lo;
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv
//   Randomised and directed checks of alu_muldiv at WIDTH=32 and WIDTH=16
//   against a behavioural model using plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_muldiv;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  op;   logic [31:0] a, b;   logic [4:0] sh;   logic start;
    logic        busy, done, zero;          logic [31:0] res, hi, lo;
    logic [3:0]  op16; logic [15:0] a16, b16; logic [3:0] sh16; logic start16;
    logic        busy16, done16, zero16;    logic [15:0] res16, hi16, lo16;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .ALUOperation(op), .A(a), .B(b), .Shamt(sh),
        .Start(start), .Busy(busy), .Done(done), .Zero(zero), .ALUResult(res),
        .Hi(hi), .Lo(lo));

    alu_muldiv #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .ALUOperation(op16), .A(a16), .B(b16), .Shamt(sh16),
        .Start(start16), .Busy(busy16), .Done(done16), .Zero(zero16), .ALUResult(res16),
        .Hi(hi16), .Lo(lo16));

    int n_cmp = 0;
    int n_err = 0;

    // Model HI/LO, index 0 = 32-bit instance, 1 = 16-bit instance
    logic [63:0] mh [2];
    logic [63:0] ml [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit seq_ok(input logic [3:0] o);
`ifdef ALU_SIGNED_MULDIV_EN
        return o == 4'd8 || o == 4'd9 || o == 4'd12 || o == 4'd13;
`else
        return o == 4'd8 || o == 4'd9;
`endif
    endfunction

    function automatic logic [31:0] comb_ref(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input int s);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'(x);
        longint uy = longint'(y);
        logic [31:0] r;
        case (o)
            4'd0:  r = x & y;
            4'd1:  r = x | y;
            4'd2:  r = ~(x | y);
            4'd3:  r = 32'(ux + uy);
            4'd4:  r = 32'(ux - uy);
            4'd5:  r = 32'(ux * (longint'(1) << s));
            4'd6:  r = 32'(sx >>> s);
            4'd7:  r = 32'(ux / (longint'(1) << s));
            4'd14: r = (sx < sy) ? 32'd1 : 32'd0;
            4'd15: r = {y[15:0], 16'h0000};
            4'd10: r = mh[0][31:0];
            4'd11: r = ml[0][31:0];
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic void md_ref(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input int w, output logic [63:0] h, output logic [63:0] l);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned ux = longint'(x) & mask;
        longint unsigned uy = longint'(y) & mask;
        longint sx = ux[w-1] ? longint'(ux) - longint'(mask) - 1 : longint'(ux);
        longint sy = uy[w-1] ? longint'(uy) - longint'(mask) - 1 : longint'(uy);
        longint unsigned p;
        h = 0;
        l = 0;
        case (o)
            4'd8:  begin p = ux * uy; h = (p >> w) & mask; l = p & mask; end
            4'd12: begin p = sx * sy; h = (p >> w) & mask; l = p & mask; end
            4'd9, 4'd13: begin
                if (uy == 0) begin
                    l = mask; h = ux;
                end else if (o == 4'd9) begin
                    l = ux / uy; h = ux % uy;
                end else begin
                    l = (sx / sy) & mask; h = (sx % sy) & mask;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic drive(input bit w16, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic s);
        if (w16) begin op16 = o; a16 = x[15:0]; b16 = y[15:0]; start16 = s; end
        else     begin op   = o; a   = x;       b   = y;       start   = s; end
    endtask

    task automatic comb_case(input string tag, input logic [3:0] o, input logic [31:0] x,
                             input logic [31:0] y, input logic [4:0] s);
        logic [31:0] e;
        op = o; a = x; b = y; sh = s; start = 1'b0;
        #1;
        e = comb_ref(o, x, y, int'(s));
        chk({tag, ":res"}, res, e);
        chk({tag, ":zero"}, zero, e == 0);
    endtask

    // Launch a multiply/divide and check cycle-accurate Busy/Done, MFHI
    // during the run, and the final HI/LO. poke re-asserts Start mid-run.
    task automatic run_md(input string tag, input bit w16, input logic [3:0] o,
                          input logic [31:0] x, input logic [31:0] y, input bit poke);
        int w = w16 ? 16 : 32;
        int k = w16 ? 1 : 0;
        logic [63:0] eh, el, old_h;
        @(posedge clk); #1;
        old_h = mh[k];
        drive(w16, o, x, y, 1'b1);
        @(posedge clk); #1;                       // edge 0
        drive(w16, OP_MFHI, $urandom, $urandom, 1'b0);
        if (!seq_ok(o)) begin
            for (int c = 0; c < 3; c++) begin
                chk({tag, ":ign_busy"}, w16 ? busy16 : busy, 0);
                chk({tag, ":ign_done"}, w16 ? done16 : done, 0);
                @(posedge clk); #1;
            end
            return;
        end
        md_ref(o, x, y, w, eh, el);
        for (int c = 0; c <= w; c++) begin        // cycles after edges 0..w
            if (c > 0) begin @(posedge clk); #1; end
            if (poke && c == 5) drive(w16, OP_DIVU, $urandom, $urandom, 1'b1);
            if (poke && c == 6) drive(w16, OP_MFHI, $urandom, $urandom, 1'b0);
            chk({tag, ":busy"}, w16 ? busy16 : busy, 1);
            chk({tag, ":done_early"}, w16 ? done16 : done, 0);
            if (c == 2) chk({tag, ":mfhi_busy"}, w16 ? 32'(res16) : res, old_h);
        end
        @(posedge clk); #1;                       // edge w+1
        chk({tag, ":done"}, w16 ? done16 : done, 1);
        chk({tag, ":busy_done"}, w16 ? busy16 : busy, 0);
        chk({tag, ":hi"}, w16 ? 32'(hi16) : hi, eh);
        chk({tag, ":lo"}, w16 ? 32'(lo16) : lo, el);
        chk({tag, ":mfhi_new"}, w16 ? 32'(res16) : res, eh);
        mh[k] = eh;
        ml[k] = el;
        @(posedge clk); #1;
        chk({tag, ":done_pulse"}, w16 ? done16 : done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] sops [4];
        bit saw;
        sops = '{4'd8, 4'd9, 4'd12, 4'd13};
        op = OP_AND; a = '0; b = '0; sh = '0; start = 1'b0;
        op16 = OP_AND; a16 = '0; b16 = '0; sh16 = '0; start16 = 1'b0;
        for (int i = 0; i < 2; i++) begin mh[i] = 0; ml[i] = 0; end
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_hi16", hi16, 0);
        #11 reset = 1'b1;

        // Directed combinational cases
        comb_case("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("add_wrap_c", res, 32'd0);
        chk("add_wrap_z", zero, 1);
        comb_case("sub", OP_SUB, 32'd5, 32'd7, 5'd0);
        chk("sub_c", res, 32'hFFFF_FFFE);
        comb_case("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("slt_c", res, 32'd1);
        comb_case("sra", OP_SRA, 32'h8000_0000, 32'd0, 5'd4);
        chk("sra_c", res, 32'hF800_0000);
        comb_case("srl", OP_SRL, 32'h8000_0000, 32'd0, 5'd4);
        chk("srl_c", res, 32'h0800_0000);
        comb_case("lui", OP_LUI, 32'd0, 32'h0000_1234, 5'd0);
        chk("lui_c", res, 32'h1234_0000);

        // Random combinational
        repeat (200) comb_case("rnd_comb", 4'($urandom_range(0, 15)), $urandom, $urandom,
                               5'($urandom_range(0, 31)));

        // Directed multiply/divide
        run_md("multu", 0, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
        chk("multu_hi_c", hi, 32'd1);
        chk("multu_lo_c", lo, 32'hFFFF_FFFE);
        comb_case("mflo", OP_MFLO, $urandom, $urandom, 5'd0);
        run_md("divu", 0, OP_DIVU, 32'd100, 32'd7, 1'b0);
        chk("divu_lo_c", lo, 32'd14);
        chk("divu_hi_c", hi, 32'd2);
        run_md("div0", 0, OP_DIVU, 32'd9, 32'd0, 1'b0);
        chk("div0_lo_c", lo, 32'hFFFF_FFFF);
        chk("div0_hi_c", hi, 32'd9);
`ifdef ALU_SIGNED_MULDIV_EN
        run_md("div_s", 0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_s_lo_c", lo, 32'hFFFF_FFFD);
        chk("div_s_hi_c", hi, 32'hFFFF_FFFF);
        run_md("mult_s", 0, OP_MULT, 32'hFFFF_FFFD, 32'd4, 1'b0);
        chk("mult_s_hi_c", hi, 32'hFFFF_FFFF);
        chk("mult_s_lo_c", lo, 32'hFFFF_FFF4);
`else
        run_md("mult_off", 0, 4'b1100, 32'd3, 32'd4, 1'b0);
`endif
        run_md("multu16", 1, OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        chk("multu16_hi_c", hi16, 16'hFFFE);
        chk("multu16_lo_c", lo16, 16'h0001);

        // Random multiply/divide on both widths
        for (int i = 0; i < 10; i++) begin
            logic [31:0] x, y;
            x = $urandom >> $urandom_range(0, 31);
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            run_md("rnd_md", i[0], sops[$urandom_range(0, 3)], x, y, 1'b0);
        end

        // Make sure HI is non-zero, then reset mid-multiply
        run_md("pre_rst", 0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(posedge clk); #1;
        drive(0, OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        for (int i = 0; i < 2; i++) begin mh[i] = 0; ml[i] = 0; end
        @(negedge clk);
        reset = 1'b1;
        saw = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1;
        end
        chk("abort_no_done", saw, 0);
        comb_case("mfhi_after_rst", OP_MFHI, $urandom, $urandom, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
